// File: rtl/fetcher.sv
// Instruction fetch stage: walks [start_pc, start_pc+inst_count) issuing one memory read per word.
// Optional FETCHER_NOP_SKIP_EN drops opcode-0 words in FETCH instead of presenting them.
module fetcher #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  input  logic [ADDR_WIDTH-1:0] inst_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [INST_WIDTH-1:0] mem_read_data,
  output logic [INST_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  input  logic                  instruction_ready,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc, pc_next;
  logic [ADDR_WIDTH-1:0]   remaining, remaining_next;
  logic [INST_WIDTH-1:0]   instruction_next;
  logic                    last_word;

  assign last_word = (remaining == ADDR_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      remaining   <= '0;
      instruction <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      remaining   <= remaining_next;
      instruction <= instruction_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    remaining_next   = remaining;
    instruction_next = instruction;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (inst_count == '0) begin
            state_next = S_DONE;
          end else begin
            pc_next        = start_pc;
            remaining_next = inst_count;
            state_next     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (mem_read_ready) begin
`ifdef FETCHER_NOP_SKIP_EN
          // A NOP still consumes one slot of inst_count; the next address is re-issued directly.
          if (mem_read_data[INST_WIDTH-1 -: 4] == 4'b0000) begin
            pc_next        = pc + ADDR_WIDTH'(1);
            remaining_next = remaining - ADDR_WIDTH'(1);
            state_next     = last_word ? S_DONE : S_FETCH;
          end else begin
            instruction_next = mem_read_data;
            state_next       = S_HOLD;
          end
`else
          instruction_next = mem_read_data;
          state_next       = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        if (instruction_ready) begin
          pc_next        = pc + ADDR_WIDTH'(1);
          remaining_next = remaining - ADDR_WIDTH'(1);
          state_next     = last_word ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_DONE);
  assign mem_read_valid    = (state == S_FETCH);
  assign instruction_valid = (state == S_HOLD);
  assign mem_read_address  = pc;
  assign pc_out            = pc;

endmodule
